pn_seq_checker: RTL and testbench

- Receive-side counterpart of the team's variable-length PN generator.
- Consumes a serial bit stream produced by the generator, with the same N and char_poly.
- Self-synchronises an internal LFSR replica to the stream, declares lock, then counts bit errors against the predicted sequence.
- Sits after the channel / loopback path, feeding the BER display logic.

---
 rtl/pn_seq_checker_if.sv | 22 ++
 rtl/pn_seq_checker.sv | 180 ++++++++++++++++++
 tb/tb_pn_seq_checker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pn_seq_checker_if.sv
// Stream and status bundle between a PN bit source (master) and pn_seq_checker (slave).
interface pn_seq_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             bit_in;
  logic             bit_valid;
  logic             locked;
  logic             err_pulse;
  logic             lost;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output bit_in, bit_valid,
    input  locked, err_pulse, lost, bit_count, err_count
  );

  modport slave (
    input  bit_in, bit_valid,
    output locked, err_pulse, lost, bit_count, err_count
  );
endinterface

// File: rtl/pn_seq_checker.sv
// Self-synchronising PN sequence checker: FILL -> VERIFY -> LOCKED, then bit/error counting.
// Optional macro PN_CHK_FLYWHEEL_EN: when defined, LOCKED advances the replica on its own predictions.
module pn_seq_checker #(
  parameter int MAX_N       = 13,
  parameter int CNT_W       = 16,
  parameter int LOCK_THRESH = 8,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [3:0]       N,
  input  logic [MAX_N-1:0] char_poly,
  pn_seq_checker_if.slave  stream
);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [MAX_N-1:0] r_q;
  logic [MAX_N-1:0] poly_q;
  logic [3:0]       n_q;
  logic [3:0]       fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [LW-1:0]    miss_cnt;
  logic             cap_pending;
  logic             locked_q;
  logic             err_pulse_q;
  logic             lost_q;
  logic [CNT_W-1:0] bit_count_q;
  logic [CNT_W-1:0] err_count_q;

  logic [3:0]       n_live;
  logic [3:0]       n_use;
  logic [MAX_N-1:0] poly_live;
  logic [MAX_N-1:0] poly_use;
  logic [MAX_N-1:0] r_shr;
  logic [MAX_N-1:0] r_next;
  logic             pred;
  logic             hit;
  logic             shift_bit;

  function automatic logic [3:0] clamp_n(input logic [3:0] n);
    if (n < 4'd2)
      return 4'd2;
    else if (n > 4'(MAX_N))
      return 4'(MAX_N);
    return n;
  endfunction

  function automatic logic [MAX_N-1:0] low_mask(input logic [3:0] n);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_N; i++)
      m[i] = (i < int'(n));
    return m;
  endfunction

  // On the capture cycle the live N/char_poly are already in force for that bit.
  assign n_live    = clamp_n(N);
  assign poly_live = char_poly & low_mask(n_live);
  assign n_use     = cap_pending ? n_live : n_q;
  assign poly_use  = cap_pending ? poly_live : poly_q;

  assign pred = ^(r_q & poly_use);
  assign hit  = (stream.bit_in == pred);
  assign r_shr = r_q >> 1;

`ifdef PN_CHK_FLYWHEEL_EN
  assign shift_bit = (state == LOCKED) ? pred : stream.bit_in;
`else
  assign shift_bit = stream.bit_in;
`endif

  // New bit lands at position n-1; everything at or above n stays zero.
  always_comb begin
    r_next = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i == int'(n_use) - 1)
        r_next[i] = shift_bit;
      else if (i < int'(n_use) - 1)
        r_next[i] = r_shr[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      r_q         <= '0;
      poly_q      <= '0;
      n_q         <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      cap_pending <= 1'b1;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lost_q      <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      lost_q      <= 1'b0;
      if (restart) begin
        state       <= FILL;
        r_q         <= '0;
        poly_q      <= poly_live;
        n_q         <= n_live;
        fill_cnt    <= '0;
        match_cnt   <= '0;
        miss_cnt    <= '0;
        cap_pending <= 1'b0;
        locked_q    <= 1'b0;
        bit_count_q <= '0;
        err_count_q <= '0;
      end else begin
        if (cap_pending) begin
          poly_q      <= poly_live;
          n_q         <= n_live;
          cap_pending <= 1'b0;
        end
        if (stream.bit_valid) begin
          r_q <= r_next;
          case (state)
            FILL: begin
              if (fill_cnt == n_use - 4'd1) begin
                state     <= VERIFY;
                fill_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                fill_cnt <= fill_cnt + 4'd1;
              end
            end
            VERIFY: begin
              if (!hit) begin
                match_cnt <= '0;
              end else if (match_cnt == MW'(LOCK_THRESH - 1)) begin
                state     <= LOCKED;
                locked_q  <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end
            LOCKED: begin
              if (bit_count_q != '1)
                bit_count_q <= bit_count_q + CNT_W'(1);
              if (hit) begin
                miss_cnt <= '0;
              end else begin
                err_pulse_q <= 1'b1;
                if (err_count_q != '1)
                  err_count_q <= err_count_q + CNT_W'(1);
                if (miss_cnt == LW'(LOSS_THRESH - 1)) begin
                  state    <= FILL;
                  locked_q <= 1'b0;
                  lost_q   <= 1'b1;
                  fill_cnt <= '0;
                  miss_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + LW'(1);
                end
              end
            end
            default: state <= FILL;
          endcase
        end
      end
    end
  end

  assign stream.locked    = locked_q;
  assign stream.err_pulse = err_pulse_q;
  assign stream.lost      = lost_q;
  assign stream.bit_count = bit_count_q;
  assign stream.err_count = err_count_q;
endmodule

// File: tb/tb_pn_seq_checker.sv
// Scoreboard bench for pn_seq_checker: driver queues expected events, a negedge monitor pops and compares.
module tb_pn_seq_checker;
`ifdef PN_CHK_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif
  localparam int EV_LOCK = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_LOST = 2;

  typedef struct {
    int kind;
    int idx;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic [3:0]  N;
  logic [12:0] char_poly;
  logic        sat_restart = 1'b0;
  logic [3:0]  sat_n = 4'd2;
  logic [12:0] sat_poly = 13'h0003;

  pn_seq_checker_if #(.CNT_W(16)) sif ();
  pn_seq_checker_if #(.CNT_W(4))  sat_if ();

  pn_seq_checker dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .N         (N),
    .char_poly (char_poly),
    .stream    (sif)
  );

  pn_seq_checker #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .restart   (sat_restart),
    .N         (sat_n),
    .char_poly (sat_poly),
    .stream    (sat_if)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   bits_fed = 0;
  ev_t  exp_q[$];
  logic hist[$];
  logic pat4 [0:14];
  logic pat3 [0:2];
  logic g13  [0:44];
  logic prev_locked = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic seeEvent(input int kind, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_%s: got event at bit %0d expected none", name, bits_fed);
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, "_kind"}, kind, e.kind);
      checkOutput({name, "_bit"}, bits_fed, e.idx);
    end
  endtask

  always @(negedge clk) begin
    if (sif.locked === 1'b1 && prev_locked !== 1'b1) seeEvent(EV_LOCK, "lock");
    if (sif.err_pulse === 1'b1) seeEvent(EV_ERR, "err_pulse");
    if (sif.lost === 1'b1) seeEvent(EV_LOST, "lost");
    prev_locked = sif.locked;
  end

  task automatic applyStimulus(input logic b, input bit lk, input bit er, input bit ls);
    if (lk) exp_q.push_back('{EV_LOCK, bits_fed + 1});
    if (er) exp_q.push_back('{EV_ERR, bits_fed + 1});
    if (ls) exp_q.push_back('{EV_LOST, bits_fed + 1});
    @(negedge clk);
    sif.bit_in    = b;
    sif.bit_valid = 1'b1;
    @(posedge clk);
    bits_fed++;
    hist.push_back(b);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    sif.bit_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic applyRestart(input logic with_bit);
    @(negedge clk);
    restart       = 1'b1;
    sif.bit_valid = with_bit;
    sif.bit_in    = 1'b1;
    @(posedge clk);
    bits_fed = 0;
    hist.delete();
    @(negedge clk);
    restart       = 1'b0;
    sif.bit_valid = 1'b0;
  endtask

  task automatic sendSat(input logic b);
    @(negedge clk);
    sat_if.bit_in    = b;
    sat_if.bit_valid = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic b;
    int   n;
    reset            = 1'b1;
    restart          = 1'b0;
    N                = 4'd4;
    char_poly        = 13'h0003;
    sif.bit_in       = 1'b0;
    sif.bit_valid    = 1'b0;
    sat_if.bit_in    = 1'b0;
    sat_if.bit_valid = 1'b0;
    pat4 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    pat3 = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 45; k++) begin
      if (k < 13) g13[k] = (k == 0);
      else        g13[k] = g13[k-13] ^ g13[k-12] ^ g13[k-10] ^ g13[k-9];
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_locked", sif.locked, 0);
    checkOutput("reset_err_pulse", sif.err_pulse, 0);
    checkOutput("reset_lost", sif.lost, 0);
    checkOutput("reset_bit_count", sif.bit_count, 0);
    checkOutput("reset_err_count", sif.err_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // N=4, poly 0x3: 4 fill bits + 8 verified bits -> lock on bit 12
    for (int k = 0; k < 12; k++) applyStimulus(pat4[k % 15], k == 11, 1'b0, 1'b0);
    #1;
    checkOutput("acq_locked", sif.locked, 1);
    checkOutput("acq_err_count", sif.err_count, 0);
    checkOutput("acq_bit_count", sif.bit_count, 0);
    for (int k = 12; k < 42; k++) applyStimulus(pat4[k % 15], 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("run30_bit_count", sif.bit_count, 30);
    checkOutput("run30_err_count", sif.err_count, 0);

    // One flipped bit; self-synchronous replica re-mispredicts when it sits in taps 1 and 0
    for (int j = 0; j < 10; j++) begin
      b = pat4[(42 + j) % 15];
      if (j == 0) b = ~b;
      applyStimulus(b, 1'b0, (j == 0) || (!FLY && (j == 3 || j == 4)), 1'b0);
    end
    #1;
    checkOutput("single_err_count", sif.err_count, FLY ? 1 : 3);
    checkOutput("single_locked", sif.locked, 1);
    checkOutput("single_bit_count", sif.bit_count, 40);

    applyRestart(1'b1);
    #1;
    checkOutput("restart_locked", sif.locked, 0);
    checkOutput("restart_bit_count", sif.bit_count, 0);
    checkOutput("restart_err_count", sif.err_count, 0);

    // Gapped acquisition: lock still lands on the 12th valid bit
    for (int k = 0; k < 12; k++) begin
      applyStimulus(pat4[k % 15], k == 11, 1'b0, 1'b0);
      idleCycle();
    end
    #1;
    checkOutput("gap_locked", sif.locked, 1);

    // Four consecutive mispredicted bits drop lock
    for (int j = 0; j < 4; j++) begin
      n = hist.size();
      b = FLY ? ~pat4[(12 + j) % 15] : ~(hist[n-4] ^ hist[n-3]);
      applyStimulus(b, 1'b0, 1'b1, j == 3);
    end
    #1;
    checkOutput("loss_locked", sif.locked, 0);
    checkOutput("loss_err_count", sif.err_count, 4);
    checkOutput("loss_bit_count", sif.bit_count, 4);
    for (int k = 16; k < 28; k++) applyStimulus(pat4[k % 15], k == 27, 1'b0, 1'b0);
    #1;
    checkOutput("reacq_locked", sif.locked, 1);
    checkOutput("reacq_err_count", sif.err_count, 4);
    checkOutput("reacq_bit_count", sif.bit_count, 4);

    // N=0 clamps to 2; later N/poly changes without restart are ignored
    N         = 4'd0;
    char_poly = 13'h1FFF;
    applyRestart(1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(pat3[k % 3], k == 9, 1'b0, 1'b0);
    N         = 4'd4;
    char_poly = 13'h0003;
    for (int k = 10; k < 16; k++) applyStimulus(pat3[k % 3], 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("n0_locked", sif.locked, 1);
    checkOutput("n0_err_count", sif.err_count, 0);
    checkOutput("n0_bit_count", sif.bit_count, 6);

    // N=13, poly 0x001B, generator seeded with 1
    N         = 4'd13;
    char_poly = 13'h001B;
    applyRestart(1'b0);
    for (int k = 0; k < 31; k++) applyStimulus(g13[k], k == 20, 1'b0, 1'b0);
    #1;
    checkOutput("n13_locked", sif.locked, 1);
    checkOutput("n13_bit_count", sif.bit_count, 10);
    checkOutput("n13_err_count", sif.err_count, 0);

    // Error bit raises err_pulse, but async reset between edges wipes it before the monitor samples
    applyStimulus(~g13[31], 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_locked", sif.locked, 0);
    checkOutput("areset_err_pulse", sif.err_pulse, 0);
    checkOutput("areset_lost", sif.lost, 0);
    checkOutput("areset_bit_count", sif.bit_count, 0);
    checkOutput("areset_err_count", sif.err_count, 0);
    @(negedge clk);
    reset         = 1'b0;
    sif.bit_valid = 1'b0;

    // 4-bit counters on the second instance: all-zero stream locks, then bit_count saturates at 15
    for (int i = 0; i < 10; i++) sendSat(1'b0);
    #1;
    checkOutput("sat_locked", sat_if.locked, 1);
    checkOutput("sat_bit_count_start", sat_if.bit_count, 0);
    for (int i = 0; i < 14; i++) sendSat(1'b0);
    #1;
    checkOutput("sat_bit_count_14", sat_if.bit_count, 14);
    for (int i = 0; i < 1; i++) sendSat(1'b0);
    #1;
    checkOutput("sat_bit_count_max", sat_if.bit_count, 15);
    for (int i = 0; i < 5; i++) sendSat(1'b0);
    #1;
    checkOutput("sat_bit_count_hold", sat_if.bit_count, 15);
    checkOutput("sat_err_count", sat_if.err_count, 0);
    @(negedge clk);
    sat_if.bit_valid = 1'b0;

    repeat (3) @(posedge clk);
    checkOutput("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
